uart_cmd_comm: RTL and testbench

Host-side serial front end of the DSO digital core. Receives 8N1 UART bytes from the host, assembles three bytes (MSB first) into the 24-bit command, and holds it with `cmd_rdy` until the core acknowledges with `clr_cmd_rdy`. Also serialises the core's one-byte responses on `TX` and reports completion with a `resp_sent` pulse. Sits directly upstream of the digital core's command-processing unit.

---
 rtl/uart_cmd_comm.sv | 121 ++++++++++++
 tb/tb_uart_cmd_comm.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_comm.sv
// uart_cmd_comm: 8N1 host UART; assembles 3-byte commands and serialises 1-byte responses.
// Define UART_CMD_TIMEOUT_EN to drop partial commands after an inter-byte gap of TIMEOUT_BITS bit times.
`timescale 1ns/1ps
module uart_cmd_comm #(
  parameter int BAUD_DIV = 347,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [23:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp_data,
  input  logic        send_resp,
  output logic        resp_sent
);
  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam int HALF = BAUD_DIV / 2;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_st_t;
  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_STOP, T_DONE} tx_st_t;
  rx_st_t rx_state, rx_next;
  tx_st_t tx_state, tx_next;
  logic rx_s1, rx_s2, rx_prev, rx_fall, rx_samp, byte_ok, expire, tx_tick;
  logic [CW-1:0] rx_cnt, tx_cnt;
  logic [2:0] rx_bit, tx_bit;
  logic [7:0] rx_sh, tx_sh;
  logic [1:0] byte_idx;
  logic [15:0] hold;
  assign rx_fall = rx_prev & ~rx_s2;
  assign rx_samp = (rx_state == R_START) ? (rx_cnt == CW'(HALF - 1))
                                         : (rx_state != R_IDLE) && (rx_cnt == CW'(BAUD_DIV - 1));
  assign tx_tick = tx_cnt == CW'(BAUD_DIV - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= R_IDLE;
      tx_state <= T_IDLE;
    end else begin
      rx_state <= rx_next;
      tx_state <= tx_next;
    end
  end
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      R_IDLE:  if (rx_fall) rx_next = R_START;
      R_START: if (rx_samp) rx_next = rx_s2 ? R_IDLE : R_DATA;
      R_DATA:  if (rx_samp && rx_bit == 3'd7) rx_next = R_STOP;
      R_STOP:  if (rx_samp) rx_next = R_IDLE;
      default: rx_next = R_IDLE;
    endcase
  end
  assign byte_ok = (rx_state == R_STOP) && rx_samp && rx_s2;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {rx_s1, rx_s2, rx_prev} <= 3'b111;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sh <= '0;
    end else begin
      {rx_s1, rx_s2, rx_prev} <= {RX, rx_s1, rx_s2};
      rx_cnt <= (rx_state == R_IDLE || rx_samp) ? '0 : rx_cnt + CW'(1);
      rx_bit <= (rx_state == R_DATA) ? rx_bit + {2'b0, rx_samp} : 3'd0;
      if (rx_state == R_DATA && rx_samp) rx_sh <= {rx_s2, rx_sh[7:1]};
    end
  end
`ifdef UART_CMD_TIMEOUT_EN
  localparam int GL = TIMEOUT_BITS * BAUD_DIV;
  localparam int GW = $clog2(GL + 1);
  logic [GW-1:0] gap;
  assign expire = (gap == GW'(GL)) && (rx_state == R_IDLE);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) gap <= '0;
    else gap <= (byte_ok || byte_idx == 2'd0) ? '0 : (gap == GW'(GL)) ? gap : gap + GW'(1);
  end
`else
  assign expire = TIMEOUT_BITS < 0;
`endif
  // cmd only moves on the third byte, so a pending command survives the next one's first bytes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx <= '0;
      hold <= '0;
      cmd <= '0;
      cmd_rdy <= 1'b0;
    end else begin
      byte_idx <= byte_ok ? ((byte_idx == 2'd2) ? 2'd0 : byte_idx + 2'd1) : expire ? 2'd0 : byte_idx;
      if (byte_ok && byte_idx == 2'd0) hold[15:8] <= rx_sh;
      if (byte_ok && byte_idx == 2'd1) hold[7:0] <= rx_sh;
      if (byte_ok && byte_idx == 2'd2) cmd <= {hold, rx_sh};
      cmd_rdy <= (byte_ok && byte_idx == 2'd2) | (cmd_rdy & ~clr_cmd_rdy);
    end
  end
  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      T_IDLE:  if (send_resp) tx_next = T_START;
      T_START: if (tx_tick) tx_next = T_DATA;
      T_DATA:  if (tx_tick && tx_bit == 3'd7) tx_next = T_STOP;
      T_STOP:  if (tx_tick) tx_next = T_DONE;
      default: tx_next = T_IDLE;
    endcase
  end
  always_comb begin
    TX = (tx_state == T_START) ? 1'b0 : (tx_state == T_DATA) ? tx_sh[0] : 1'b1;
    resp_sent = tx_state == T_DONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_sh <= '0;
    end else begin
      tx_cnt <= (tx_state == T_IDLE || tx_state == T_DONE || tx_tick) ? '0 : tx_cnt + CW'(1);
      tx_bit <= (tx_state == T_DATA) ? tx_bit + {2'b0, tx_tick} : 3'd0;
      if (tx_state == T_IDLE && send_resp) tx_sh <= resp_data;
      else if (tx_state == T_DATA && tx_tick) tx_sh <= tx_sh >> 1;
    end
  end
endmodule

// File: tb/tb_uart_cmd_comm.sv
// tb_uart_cmd_comm: random and directed UART traffic checked against a byte-queue command model.
`timescale 1ns/1ps
module tb_uart_cmd_comm;
  localparam int B = 16;
  localparam int H = B / 2;
  localparam int LIM = 4 * B;
`ifdef UART_CMD_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif
  logic clk = 0, rst_n = 0, rx = 1, clr = 0, send = 0;
  logic tx, cmd_rdy, resp_sent;
  logic [23:0] cmd;
  logic [7:0] rdata = 0, r0, r1, r2, rb;
  int total = 0, bad = 0, cyc = 0;
  logic [7:0] q[$];
  logic [23:0] m_cmd = 0;
  logic m_rdy = 0;
  int last_ok = 0;
  uart_cmd_comm #(.BAUD_DIV(B), .TIMEOUT_BITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .RX(rx), .TX(tx), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr), .resp_data(rdata), .send_resp(send), .resp_sent(resp_sent)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic void expire_check();
    if (TMO && q.size() != 0 && cyc - last_ok > LIM) q.delete();
  endfunction
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send_byte(input logic [7:0] b, input bit stop = 1'b1);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    expire_check();
    for (int i = 0; i < 10; i++) begin
      if (i == 9) begin
        check("pre_rdy", cmd_rdy, m_rdy);
        check("pre_cmd", cmd, m_cmd);
      end
      rx = fr[i];
      idle(B);
    end
    rx = 1;
    if (stop) begin
      q.push_back(b);
      last_ok = cyc;
      if (q.size() == 3) begin
        m_cmd = {q[0], q[1], q[2]};
        m_rdy = 1;
        q.delete();
      end
    end else expire_check();
    check("cmd", cmd, m_cmd);
    check("rdy", cmd_rdy, m_rdy);
  endtask
  task automatic clr_pulse();
    clr = 1;
    @(negedge clk);
    clr = 0;
    m_rdy = 0;
    check("clr_rdy", cmd_rdy, 0);
    check("clr_cmd", cmd, m_cmd);
  endtask
  task automatic resp_chk(input logic [7:0] d);
    logic [9:0] fr;
    int pulses, at;
    fr = {1'b1, d, 1'b0};
    pulses = 0;
    at = -1;
    rdata = d;
    send = 1;
    @(negedge clk);
    send = 0;
    rdata = ~d;
    for (int j = 0; j <= 10 * B + 20; j++) begin
      if (j == 49) send = 1;
      if (j == 50) send = 0;
      if (j % B == H && j / B < 10) check($sformatf("tx_bit%0d", j / B), tx, fr[j / B]);
      if (resp_sent) begin
        pulses++;
        at = j;
      end
      @(negedge clk);
    end
    check("sent_cnt", pulses, 1);
    check("sent_at", at, 10 * B);
  endtask
  initial begin
    #500us;
    $display("FAIL watchdog total=%0d", total);
    $fatal(1, "timeout");
  end
  initial begin
    idle(3);
    check("rst_tx", tx, 1);
    check("rst_cmd", cmd, 0);
    check("rst_rdy", cmd_rdy, 0);
    check("rst_sent", resp_sent, 0);
    rst_n = 1;
    idle(3);
    send_byte(8'h12); idle(2);
    send_byte(8'h34); idle(2);
    send_byte(8'h56); idle(2);
    check("asm_cmd", cmd, 24'h123456);
    clr_pulse();
    send_byte(8'hAA); idle(3);
    send_byte(8'hBB, 1'b0); idle(3);
    send_byte(8'hCC); idle(3);
    send_byte(8'hDD); idle(3);
    if (q.size() != 0) begin
      idle(LIM + 40);
      expire_check();
    end
    send_byte(8'h01); idle(2);
    send_byte(8'h02); idle(2);
    clr = 1;
    m_rdy = 0;
    fork
      send_byte(8'h03);
      begin : waiter
        bit seen;
        seen = 0;
        for (int k = 0; k < 12 * B && !seen; k++) begin
          @(negedge clk);
          seen = cmd_rdy;
        end
        clr = 0;
        check("set_wins", seen, 1);
      end
    join
    check("coll_cmd", cmd, 24'h010203);
    send_byte(8'hFF); idle(2);
    send_byte(8'hEE); idle(2);
    check("pend_cmd", cmd, 24'h010203);
    send_byte(8'($urandom)); idle(2);
    clr_pulse();
    r0 = 8'($urandom); r1 = 8'($urandom); r2 = 8'($urandom);
    fork
      resp_chk(8'hA5);
      begin
        send_byte(r0); send_byte(r1); send_byte(r2);
      end
    join
    check("conc_cmd", cmd, {r0, r1, r2});
    idle(4);
    resp_chk(8'($urandom));
    send_byte(8'h11);
    idle(100);
    send_byte(8'h22); idle(2);
    send_byte(8'h33); idle(2);
    send_byte(8'h44); idle(2);
    check("timeout_cmd", cmd, TMO ? 24'h223344 : 24'h112233);
    for (int n = 0; n < 12; n++) begin
      rb = 8'($urandom);
      send_byte(rb, $urandom_range(0, 5) != 0);
      idle(2 + $urandom_range(0, 28));
      if ($urandom_range(0, 3) == 0) clr_pulse();
      if ($urandom_range(0, 7) == 0) idle(LIM + 40);
    end
    for (int k = 0; k < 6 && !(m_rdy && q.size() == 1); k++) begin
      send_byte(8'($urandom));
      idle(2);
    end
    rdata = 8'($urandom);
    send = 1;
    @(negedge clk);
    send = 0;
    rx = 0;
    idle(40);
    rst_n = 0;
    #1;
    check("arst_tx", tx, 1);
    check("arst_rdy", cmd_rdy, 0);
    check("arst_cmd", cmd, 0);
    @(negedge clk);
    rx = 1;
    idle(3);
    check("arst_hold_rdy", cmd_rdy, 0);
    check("arst_hold_tx", tx, 1);
    q.delete();
    m_rdy = 0;
    m_cmd = 0;
    rst_n = 1;
    idle(5);
    r0 = 8'($urandom); r1 = 8'($urandom); r2 = 8'($urandom);
    send_byte(r0); idle(2);
    send_byte(r1); idle(2);
    send_byte(r2); idle(2);
    check("post_rst_cmd", cmd, {r0, r1, r2});
    check("post_rst_rdy", cmd_rdy, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
